hplvds_link_ctrl: RTL
=====================

HPLVDS_LINK_CTRL -- requirements
Module: hplvds_link_ctrl

Interface
REQ-001 Parameters SHALL be:
- SETTLE_CYC, 16, cycles per settle phase; legal range 1..255.
- EI_DEB, 4, consecutive cycles needed to change LINK_IDLE_O; legal range 1..255.
REQ-002 Clocking SHALL be one clock, CLK_I; reset SHALL be RST_I, synchronous, active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- CLK_I  in  1  clock.
- RST_I  in  1  synchronous active-high reset.
- EN_I  in  1  link enable request.
- TX_MODE_I  in  1  1 = transmitter, 0 = receiver; sampled in OFF only.
- IDLE_REQ_I  in  1  TX electrical-idle request.
- EI_DETECT_I  in  1  EI detector output from the pad cell.
- CFG_RTERM_TRIM_I  in  4  termination trim.
- CFG_TX_BIAS_I  in  4  TX bias setting.
- RTERM_EN_O  out  1  termination enable to the pad.
- RTERM_TRIM_O  out  4  latched trim.
- RX_EN_O  out  1  receiver enable.
- RX_VCM_EN_O  out  1  receiver common-mode enable.
- EI_DETECT_EN_O  out  1  EI detector enable.
- TX_EN_O  out  1  transmitter enable.
- TX_VCM_EN_O  out  1  TX common-mode enable.
- TX_EI_O  out  1  force electrical idle.
- TX_BIAS_O  out  4  latched bias.
- READY_O  out  1  link active.
- LINK_IDLE_O  out  1  debounced RX idle.

Function
REQ-004 The FSM SHALL have states OFF, CFG, ENABLE, ACTIVE, SHUTDOWN; all outputs SHALL be registered.
REQ-005 OFF: all outputs 0 except TX_EI_O=1. EN_I=1 SHALL latch TX_MODE_I, CFG_RTERM_TRIM_I and CFG_TX_BIAS_I, then go to CFG.
REQ-006 Latched mode and config SHALL remain constant outside OFF; input changes are ignored.
REQ-007 On every entry to CFG, ENABLE or SHUTDOWN, the counter SHALL load SETTLE_CYC-1; the FSM SHALL advance on the edge where the counter equals 0. Each such state therefore lasts exactly SETTLE_CYC cycles.
REQ-008 CFG: RX mode drives RTERM_EN_O=1 and RX_VCM_EN_O=1. TX mode drives TX_VCM_EN_O=1. Next state is ENABLE.
REQ-009 ENABLE: keeps the CFG outputs and adds RX_EN_O=1 (RX mode) or TX_EN_O=1 with TX_EI_O=1 (TX mode). Next state is ACTIVE.
REQ-010 ACTIVE: READY_O=1.
- TX mode: TX_EI_O follows IDLE_REQ_I with 1-cycle latency.
- RX mode: EI_DETECT_EN_O=1.
REQ-011 READY_O SHALL rise exactly 2*SETTLE_CYC cycles after the edge at which EN_I is first sampled high in OFF.
REQ-012 RX debounce (ACTIVE only):
- LINK_IDLE_O rises on the edge completing EI_DEB consecutive sampled cycles of EI_DETECT_I=1 while LINK_IDLE_O=0.
- It falls after EI_DEB consecutive cycles of EI_DETECT_I=0 while LINK_IDLE_O=1.
- Any opposite sample SHALL clear the run counter.
- LINK_IDLE_O=0 outside RX ACTIVE.
REQ-013 EN_I=0 sampled in CFG, ENABLE or ACTIVE SHALL go to SHUTDOWN on that edge.
REQ-014 SHUTDOWN outputs: READY_O=0, RX_EN_O=0, TX_EN_O=0, EI_DETECT_EN_O=0, LINK_IDLE_O=0, TX_EI_O=1. Termination and VCM enables stay as in CFG. Next state is OFF.
REQ-015 EN_I is ignored during SHUTDOWN. If EN_I=1 on the first OFF cycle, the FSM SHALL restart CFG on that edge.
REQ-016 If EN_I falls on the same edge the counter reaches 0, SHUTDOWN SHALL take priority over advancing.
REQ-017 Counter widths SHALL be 8 bits; counters SHALL saturate, never wrap.

Reset
REQ-018 RST_I=1 SHALL, on the next edge, force OFF, clear counters and latched config, and set outputs to OFF values (TX_EI_O=1, all others 0). This SHALL apply from any state, including mid-settle.
REQ-019 Reset SHALL have priority over all other inputs.

Verification
REQ-020 RX bring-up, SETTLE_CYC=16: EN_I=1, TX_MODE_I=0, trim=4'hA -> RTERM_EN_O=1 and RTERM_TRIM_O=4'hA after edge 0; RX_EN_O=1 after edge 16; READY_O=1 and EI_DETECT_EN_O=1 after edge 32.
REQ-021 TX idle: TX ACTIVE, IDLE_REQ_I pulsed high for 3 cycles -> TX_EI_O high for exactly 3 cycles, delayed 1 cycle.
REQ-022 Debounce, EI_DEB=4: EI_DETECT_I pattern 1,1,1,0,1,1,1,1 -> LINK_IDLE_O rises on the 8th edge only; then four 0s -> falls.
REQ-023 Abort: EN_I=0 at ENABLE count 5 -> SHUTDOWN next edge, RX_EN_O=0, OFF after 16 cycles; EN_I=1 during SHUTDOWN has no effect.
REQ-024 Reset mid-ACTIVE: RST_I=1 one cycle -> all outputs at OFF values next edge; new TX_MODE_I accepted on re-enable.

Source files
------------

// File: rtl/hplvds_link_ctrl.sv
// hplvds_link_ctrl: power-up/down sequencer for an HPLVDS pad, with TX idle
// control and RX electrical-idle debounce.
module hplvds_link_ctrl #(
    parameter int SETTLE_CYC = 16,
    parameter int EI_DEB     = 4
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       EN_I,
    input  logic       TX_MODE_I,
    input  logic       IDLE_REQ_I,
    input  logic       EI_DETECT_I,
    input  logic [3:0] CFG_RTERM_TRIM_I,
    input  logic [3:0] CFG_TX_BIAS_I,
    output logic       RTERM_EN_O,
    output logic [3:0] RTERM_TRIM_O,
    output logic       RX_EN_O,
    output logic       RX_VCM_EN_O,
    output logic       EI_DETECT_EN_O,
    output logic       TX_EN_O,
    output logic       TX_VCM_EN_O,
    output logic       TX_EI_O,
    output logic [3:0] TX_BIAS_O,
    output logic       READY_O,
    output logic       LINK_IDLE_O
);
    typedef enum logic [2:0] {OFF, CFG, ENABLE, ACTIVE, SHUTDOWN} stateT;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] DEB_LAST    = 8'(EI_DEB - 1);

    stateT      state, nextState;
    logic [7:0] settleCnt, nextCnt, runCnt;
    logic       txMode, nextMode;
    logic [3:0] trimLat, biasLat, nextTrim, nextBias;
    logic       cntDone, latchCfg, rxActive, linkOn;

    assign cntDone  = settleCnt == 8'd0;
    assign latchCfg = state == OFF && EN_I;
    assign nextMode = latchCfg ? TX_MODE_I : txMode;
    assign nextTrim = latchCfg ? CFG_RTERM_TRIM_I : trimLat;
    assign nextBias = latchCfg ? CFG_TX_BIAS_I : biasLat;
    assign rxActive = state == ACTIVE && nextState == ACTIVE && !txMode;
    assign linkOn   = nextState == ENABLE || nextState == ACTIVE;

    // Shutdown wins over advancing when EN_I drops on the counter's last cycle.
    always_comb begin
        nextState = state;
        nextCnt   = cntDone ? 8'd0 : settleCnt - 8'd1;
        case (state)
            OFF: if (EN_I) begin
                nextState = CFG;
                nextCnt   = SETTLE_LOAD;
            end
            CFG, ENABLE: if (!EN_I || cntDone) begin
                nextState = !EN_I ? SHUTDOWN : (state == CFG ? ENABLE : ACTIVE);
                nextCnt   = !EN_I || state == CFG ? SETTLE_LOAD : 8'd0;
            end
            ACTIVE: if (!EN_I) begin
                nextState = SHUTDOWN;
                nextCnt   = SETTLE_LOAD;
            end
            SHUTDOWN: if (cntDone) nextState = OFF;
            default: nextState = OFF;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state          <= OFF;
            settleCnt      <= 8'd0;
            runCnt         <= 8'd0;
            txMode         <= 1'b0;
            trimLat        <= 4'd0;
            biasLat        <= 4'd0;
            RTERM_EN_O     <= 1'b0;
            RTERM_TRIM_O   <= 4'd0;
            RX_EN_O        <= 1'b0;
            RX_VCM_EN_O    <= 1'b0;
            EI_DETECT_EN_O <= 1'b0;
            TX_EN_O        <= 1'b0;
            TX_VCM_EN_O    <= 1'b0;
            TX_EI_O        <= 1'b1;
            TX_BIAS_O      <= 4'd0;
            READY_O        <= 1'b0;
            LINK_IDLE_O    <= 1'b0;
        end else begin
            state          <= nextState;
            settleCnt      <= nextCnt;
            txMode         <= nextMode;
            trimLat        <= nextTrim;
            biasLat        <= nextBias;
            RTERM_EN_O     <= nextState != OFF && !nextMode;
            RX_VCM_EN_O    <= nextState != OFF && !nextMode;
            TX_VCM_EN_O    <= nextState != OFF && nextMode;
            RX_EN_O        <= linkOn && !nextMode;
            TX_EN_O        <= linkOn && nextMode;
            EI_DETECT_EN_O <= nextState == ACTIVE && !nextMode;
            READY_O        <= nextState == ACTIVE;
            TX_EI_O        <= nextState == ACTIVE && nextMode ? IDLE_REQ_I : 1'b1;
            RTERM_TRIM_O   <= nextState == OFF ? 4'd0 : nextTrim;
            TX_BIAS_O      <= nextState == OFF ? 4'd0 : nextBias;
            // A run of samples disagreeing with the current level flips it once long enough.
            if (!rxActive) begin
                runCnt      <= 8'd0;
                LINK_IDLE_O <= 1'b0;
            end else if (EI_DETECT_I == LINK_IDLE_O) begin
                runCnt      <= 8'd0;
            end else if (runCnt >= DEB_LAST) begin
                runCnt      <= 8'd0;
                LINK_IDLE_O <= !LINK_IDLE_O;
            end else begin
                runCnt      <= runCnt == 8'hFF ? runCnt : runCnt + 8'd1;
            end
        end
    end
endmodule
